// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and hex-to-segment table for the 7-segment scanner
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;
    localparam int         DIGITS    = 4;

    typedef logic [1:0] dig_idx_t;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the least significant slice.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational hex nibble to active-low 7-segment decoder
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - 4-digit multiplexed 7-segment driver; SEG_SCAN_LZB_EN adds leading-zero blanking
module seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 2,
    parameter int DIV_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [15:0] ind_i,
    input  logic [3:0]  dp_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    logic [DIV_W-1:0] cnt;
    dig_idx_t         dig;
    logic [15:0]      snap;
    logic [3:0]       snap_dp;

    logic             tick;
    logic             frame_end;
    logic             drive;
    logic [3:0]       cur_nib;
    logic [6:0]       cur_seg;
    logic             digit_blank;

    assign tick      = (cnt == DIV_W'(CLK_DIV - 1));
    assign frame_end = tick && (dig == 2'd3);
    assign drive     = ena && (cnt >= DIV_W'(BLANK_CYC));
    assign cur_nib   = snap[{dig, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

`ifdef SEG_SCAN_LZB_EN
    // A lit decimal point on a digit ends the run of blanked leading zeros.
    logic lz3, lz2, lz1;
    assign lz3 = (snap[15:12] == 4'h0) && !snap_dp[3];
    assign lz2 = lz3 && (snap[11:8] == 4'h0) && !snap_dp[2];
    assign lz1 = lz2 && (snap[7:4] == 4'h0) && !snap_dp[1];

    always_comb begin
        digit_blank = 1'b0;
        case (dig)
            2'd3:    digit_blank = lz3;
            2'd2:    digit_blank = lz2;
            2'd1:    digit_blank = lz1;
            default: digit_blank = 1'b0;
        endcase
    end
`else
    assign digit_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            dig     <= '0;
            snap    <= 16'h0;
            snap_dp <= 4'h0;
            an_o    <= AN_OFF;
            seg_o   <= SEG_BLANK;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            frame_o <= frame_end;
            if (tick) begin
                dig <= dig + 2'd1;
            end
            if (frame_end) begin
                snap    <= ind_i;
                snap_dp <= dp_i;
            end
            // Outputs reflect the pre-edge counters and snapshot, one cycle behind.
            if (drive) begin
                an_o  <= ~(4'b0001 << dig);
                seg_o <= digit_blank ? SEG_BLANK : cur_seg;
                dp_o  <= digit_blank ? 1'b1 : ~snap_dp[dig];
            end else begin
                an_o  <= AN_OFF;
                seg_o <= SEG_BLANK;
                dp_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan at CLK_DIV=4 and CLK_DIV=2
module tb_seg_scan;

    localparam int BLANK = 1;
    localparam int DIVS [2] = '{4, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic [15:0] ind_i = 16'h0;
    logic [3:0]  dp_i = 4'h0;

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, fr_a, fr_b;

    int checks = 0;
    int errors = 0;

    int          mt [2];
    logic [15:0] msnap [2];
    logic [3:0]  mdp [2];
    int          steps_since_rst;
    int          first_frame;

    int hex_tab [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                         'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

    seg_scan #(.CLK_DIV(4), .BLANK_CYC(BLANK), .DIV_W(16)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .ind_i(ind_i), .dp_i(dp_i),
        .an_o(an_a), .seg_o(seg_a), .dp_o(dp_a), .frame_o(fr_a)
    );

    seg_scan #(.CLK_DIV(2), .BLANK_CYC(BLANK), .DIV_W(4)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .ind_i(ind_i), .dp_i(dp_i),
        .an_o(an_b), .seg_o(seg_b), .dp_o(dp_b), .frame_o(fr_b)
    );

    always #5 clk = ~clk;

    // Reference: position in the frame follows from elapsed cycles t since reset.
    function automatic void model_out(input int d, input int t, input logic [15:0] s,
                                      input logic [3:0] sd, input logic en,
                                      output logic [3:0] an, output logic [6:0] seg,
                                      output logic dp);
        int c, k, nib;
        bit blank;
        c = t % d;
        k = (t / d) % 4;
        nib = (s >> (4 * k)) & 16'hF;
        blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
        if (k > 0) begin
            blank = 1'b1;
            for (int j = 3; j >= k; j--) begin
                if (((s >> (4 * j)) & 16'hF) != 0 || sd[j]) blank = 1'b0;
            end
        end
`endif
        if (en && c >= BLANK) begin
            an  = 4'hF & ~(4'(1) << k);
            seg = blank ? 7'h7F : 7'(hex_tab[nib]);
            dp  = blank ? 1'b1 : ~sd[k];
        end else begin
            an  = 4'hF;
            seg = 7'h7F;
            dp  = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, expv, mt[0]);
        end
    endtask

    task automatic step();
        logic [3:0] ean [2];
        logic [6:0] eseg [2];
        logic       edp [2];
        logic       efr [2];
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ean[i] = 4'hF; eseg[i] = 7'h7F; edp[i] = 1'b1; efr[i] = 1'b0;
            end else begin
                model_out(DIVS[i], mt[i], msnap[i], mdp[i], ena, ean[i], eseg[i], edp[i]);
                efr[i] = (mt[i] % (4 * DIVS[i])) == (4 * DIVS[i] - 1);
            end
        end
        @(posedge clk);
        #1;
        chk("an_a",    {3'b0, an_a}, {3'b0, ean[0]});
        chk("seg_a",   seg_a,        eseg[0]);
        chk("dp_a",    {6'b0, dp_a}, {6'b0, edp[0]});
        chk("frame_a", {6'b0, fr_a}, {6'b0, efr[0]});
        chk("an_b",    {3'b0, an_b}, {3'b0, ean[1]});
        chk("seg_b",   seg_b,        eseg[1]);
        chk("dp_b",    {6'b0, dp_b}, {6'b0, edp[1]});
        chk("frame_b", {6'b0, fr_b}, {6'b0, efr[1]});
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mt[i] = 0; msnap[i] = 16'h0; mdp[i] = 4'h0;
            end else begin
                if (efr[i]) begin
                    msnap[i] = ind_i; mdp[i] = dp_i;
                end
                mt[i]++;
            end
        end
        if (rst) begin
            steps_since_rst = 0; first_frame = -1;
        end else begin
            steps_since_rst++;
            if (fr_a && first_frame < 0) first_frame = steps_since_rst;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        ind_i = 16'h1234;
        run(16);
        checks++;
        assert (first_frame === 16) else begin
            errors++;
            $error("FAIL first_frame observed=%0d expected=16", first_frame);
        end
        run(16);

        run(6);
        ind_i = 16'hABCD;
        run(26);

        ena = 1'b0;
        run(16);
        ena = 1'b1;
        run(16);

        dp_i = 4'b0100;
        ind_i = 16'h8888;
        run(32);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) ind_i = 16'($urandom);
            if ($urandom_range(0, 7) == 0) dp_i = 4'($urandom);
            ena = ($urandom_range(0, 3) != 0);
            step();
        end
        ena = 1'b1;

        run(5);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        dp_i = 4'h0;
        ind_i = 16'h0050;
        run(40);
        ind_i = 16'h0000;
        run(40);
        dp_i = 4'b0100;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
